// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: controller state encoding
// and the width of the wait-state counter.
package mem_pkg;

  // Width of the wait counter; wide enough for WAIT_CYCLES up to 15.
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for the memory access unit. Counts up from zero while
// enabled and stops at the terminal value 'last'; tc flags that value.
module mem_wait_counter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WAIT_W-1:0] last,
  output logic              tc
);

  logic [WAIT_W-1:0] count_reg;

  assign tc = (count_reg == last);

  // Clear wins over enable; holding at 'last' lets ACCESS stretch indefinitely.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers plus a three-state controller that
// drives active-low SRAM strobes for WAIT_CYCLES cycles per access.
// Optional build macro MEM_READY_EN adds a mem_ready input that stretches
// the access until the memory reports ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MEM_READY_EN
  input  logic        mem_ready,
`endif
  input  logic [15:0] bus,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        mem_start,
  input  logic        mem_write,
  input  logic [15:0] mem_data_in,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        busy,
  output logic        done
);

  // Counter value reached on the final ACCESS cycle.
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        write_reg;
  logic [15:0] mar_reg;
  logic [15:0] mdr_reg;
  logic        tc;
  logic        ready;
  logic        idle;
  logic        start_ok;
  logic        access_exit;

`ifdef MEM_READY_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  assign idle        = (state_reg == IDLE);
  assign start_ok    = idle && mem_start;
  assign access_exit = (state_reg == ACCESS) && tc && ready;

  assign mar          = mar_reg;
  assign mdr          = mdr_reg;
  assign mem_addr     = mar_reg;
  assign mem_data_out = mdr_reg;

  mem_wait_counter u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (state_reg == ACCESS),
    .last  (LAST),
    .tc    (tc)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and strobe/status outputs.
  always_comb begin
    state_next = state_reg;
    mem_ce_n   = 1'b1;
    mem_oe_n   = 1'b1;
    mem_we_n   = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_start) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_ce_n = 1'b0;
        mem_oe_n = write_reg;
        mem_we_n = !write_reg;
        busy     = 1'b1;
        if (tc && ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // MAR/MDR and access-type latch. Loads are accepted only in IDLE so the
  // address and write data stay stable for the whole access; a load in the
  // start cycle lands on the same edge and is therefore used by the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      mar_reg   <= '0;
      mdr_reg   <= '0;
      write_reg <= 1'b0;
    end else begin
      if (idle) begin
        if (ld_mar) begin
          mar_reg <= bus;
        end
        if (ld_mdr && !mio_en) begin
          mdr_reg <= bus;
        end
        if (mem_start) begin
          write_reg <= mem_write;
        end
      end
      if (access_exit && !write_reg) begin
        mdr_reg <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes the expected outcome
// of each access, a negedge monitor checks strobes and completion.
module tb_mem_access_unit;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
`ifdef MEM_READY_EN
  logic        mem_ready;
`endif
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, mem_start, mem_write;
  logic [15:0] mem_data_in;
  logic [15:0] mar, mdr, mem_addr, mem_data_out;
  logic        mem_ce_n, mem_oe_n, mem_we_n, busy, done;

  mem_access_unit #(.WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef MEM_READY_EN
    .mem_ready    (mem_ready),
`endif
    .bus          (bus),
    .ld_mar       (ld_mar),
    .ld_mdr       (ld_mdr),
    .mio_en       (mio_en),
    .mem_start    (mem_start),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mar          (mar),
    .mdr          (mdr),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_ce_n     (mem_ce_n),
    .mem_oe_n     (mem_oe_n),
    .mem_we_n     (mem_we_n),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdr_after;
    logic        wr;
    int          len;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          run = 0;
  logic        in_abort = 1'b0;
  logic [15:0] model_mar = 16'h0;
  logic [15:0] model_mdr = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle strobe checks during an access, completion checks on done.
  always @(negedge clk) begin
    exp_t e;
    if (in_abort) begin
      if (done) chk("abort_done", done, 1'b0);
    end else if (!reset) begin
      if (!mem_ce_n) begin
        if (q.size() == 0) begin
          chk("strobe_without_txn", mem_ce_n, 1'b1);
        end else begin
          run++;
          chk("oe_n", mem_oe_n, q[0].wr);
          chk("we_n", mem_we_n, !q[0].wr);
          chk("mem_addr", mem_addr, q[0].addr);
          chk("busy_access", busy, 1'b1);
          if (q[0].wr) chk("mem_data_out", mem_data_out, q[0].wdata);
        end
      end else begin
        chk("idle_strobes", {mem_oe_n, mem_we_n}, 2'b11);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", done, 1'b0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("access_len", run, e.len);
          chk("mdr", mdr, e.mdr_after);
          chk("mar", mar, e.addr);
          chk("busy_done", busy, 1'b1);
          $display("txn wr=%0d addr=%h mdr=%h len=%0d cyc=%0d", e.wr, mar, mdr, run, cyc);
        end
        run = 0;
      end
    end
  end

  task automatic clear_inputs();
    bus = 16'h0; ld_mar = 0; ld_mdr = 0; mio_en = 0; mem_start = 0; mem_write = 0;
`ifdef MEM_READY_EN
    mem_ready = 0;
`endif
  endtask

  task automatic idle_cycle(input logic lmar, input logic lmdr, input logic mio, input logic [15:0] b);
    ld_mar = lmar; ld_mdr = lmdr; mio_en = mio; bus = b;
    if (lmar) model_mar = b;
    if (lmdr && !mio) model_mdr = b;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic access(input logic wr, input logic lmar, input logic lmdr, input logic mio,
                        input logic [15:0] b, input logic [15:0] rd, input int extra, input logic noisy);
    exp_t e;
    ld_mar = lmar; ld_mdr = lmdr; mio_en = mio; bus = b;
    mem_start = 1; mem_write = wr; mem_data_in = rd;
`ifdef MEM_READY_EN
    mem_ready = 1'($urandom % 2);
`endif
    if (lmar) model_mar = b;
    if (lmdr && !mio) model_mdr = b;
    e.addr = model_mar;
    e.wdata = model_mdr;
    e.wr = wr;
    e.mdr_after = wr ? model_mdr : rd;
    e.len = W + extra;
    e.done_cyc = cyc + 1 + W + extra;
    q.push_back(e);
    model_mdr = e.mdr_after;
    @(posedge clk); #1;
    for (int k = 1; k <= W + extra + 1; k++) begin
      if (noisy) begin
        ld_mar = 1'($urandom % 2); ld_mdr = 1'($urandom % 2); mio_en = 1'($urandom % 2);
        mem_start = 1'($urandom % 2); mem_write = 1'($urandom % 2); bus = 16'($urandom);
      end else begin
        ld_mar = 0; ld_mdr = 0; mem_start = 0;
      end
`ifdef MEM_READY_EN
      mem_ready = (k >= W + extra) ? 1'b1 : ((k < W) ? 1'($urandom % 2) : 1'b0);
`endif
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  function automatic int pick_extra();
`ifdef MEM_READY_EN
    return int'($urandom % 4);
`else
    return 0;
`endif
  endfunction

  initial begin
    reset = 1; mem_data_in = 16'h0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mar", mar, 16'h0);
    chk("rst_mdr", mdr, 16'h0);
    chk("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("rst_busy_done", {busy, done}, 2'b00);
    reset = 0;
    @(posedge clk); #1;

    // Read of 0x3000 returning 0xBEEF.
    idle_cycle(1, 0, 0, 16'h3000);
    access(0, 0, 0, 0, 16'h0, 16'hBEEF, 0, 0);
    // Write 0x1234 to 0x0040.
    idle_cycle(1, 0, 0, 16'h0040);
    idle_cycle(0, 1, 0, 16'h1234);
    access(1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    // Read with loads and restarts pulsed while busy.
    access(0, 0, 0, 0, 16'h0, 16'hA5A5, 0, 1);
    // Bus load to MDR with the memory path selected is ignored.
    idle_cycle(0, 1, 1, 16'h00AA);
    access(1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    // Loads in the same cycle as the start are used by that access.
    access(0, 1, 0, 0, 16'h0A0A, 16'h7777, 0, 0);
    access(1, 0, 1, 0, 16'h5555, 16'h0, 0, 0);
`ifdef MEM_READY_EN
    // Ready held low for three extra cycles.
    access(0, 0, 0, 0, 16'h0, 16'hC0DE, 3, 0);
`endif

    // Reset held two cycles in the middle of a write.
    in_abort = 1;
    idle_cycle(1, 1, 0, 16'h2222);
    mem_start = 1; mem_write = 1;
    @(posedge clk); #1;
    mem_start = 0; mem_write = 0;
    reset = 1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    chk("abort_mar", mar, 16'h0);
    chk("abort_mdr", mdr, 16'h0);
    chk("abort_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("abort_busy", busy, 1'b0);
    model_mar = 16'h0; model_mdr = 16'h0;
    repeat (4) begin @(posedge clk); #1; end
    in_abort = 0;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom % 2 == 1)
        idle_cycle(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 16'($urandom));
      access(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
             16'($urandom), 16'($urandom), pick_extra(), 1);
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("pending_txns", q.size(), 0);
    chk("final_mar", mar, model_mar);
    chk("final_mdr", mdr, model_mdr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
